// File: rtl/regfile_multiport_pkg.sv
// Shared constants for the multiport register file and its busy scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a (no handshakes).
package regfile_multiport_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  // Hard-wired zero register: reads 0, ignores writes, never busy.
  localparam int REG0 = 0;
  typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by an issue, cleared by a write, issue wins on conflict.
// Latency: busy state updates on the rising clk edge after issue/clear.
// Backpressure: none; callers pre-qualify issue/clear (nonzero, in-range address).
module regfile_scoreboard
  import regfile_multiport_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_vld_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic             clr_vld_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [DEPTH-1:0] busy_o
);

  logic [DEPTH-1:0] busy_q;

  // Busy bit per register; a same-cycle issue overrides the clear (newer producer wins).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int i = REG0 + 1; i < DEPTH; i++) begin
        if (issue_vld_i && (issue_addr_i == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (clr_vld_i && (clr_addr_i == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_multiport.sv
// Flop-based register file: NREAD combinational read ports, one write port, busy scoreboard.
// Latency: reads are zero-latency; writes land on the rising edge (optionally forwarded same cycle).
// Backpressure: none; out-of-range or r0 writes/issues are silently dropped.
module regfile_multiport
  import regfile_multiport_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NREAD  = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREAD*AW-1:0]    regRaddr,
  output logic [NREAD*WIDTH-1:0] regRcontent,
  output logic [NREAD-1:0]       regRbusy,
  input  logic [AW-1:0]          regWaddr,
  input  logic [WIDTH-1:0]       data,
  input  logic                   regWflag,
  input  logic                   issueFlag,
  input  logic [AW-1:0]          issueAddr,
  output logic                   anyBusy
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_en;
  logic             iss_en;
  logic [AW-1:0]    rd_addr;

  // Address names a real, writable register (not r0, below DEPTH).
  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (a != AW'(REG0));
  endfunction

  // Gating with rst_n keeps forwarding from leaking write data while reset is held.
  assign wr_en  = rst_n && regWflag  && valid_addr(regWaddr);
  assign iss_en = rst_n && issueFlag && valid_addr(issueAddr);

  // Storage array; entry 0 is only ever reset, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = REG0 + 1; i < DEPTH; i++) begin
        if (regWaddr == AW'(i)) begin
          mem_q[i] <= data;
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_vld_i  (iss_en),
    .issue_addr_i (issueAddr),
    .clr_vld_i    (wr_en),
    .clr_addr_i   (regWaddr),
    .busy_o       (busy)
  );

  // Independent read ports with optional same-cycle forwarding of the write port.
  always_comb begin
    regRcontent = '0;
    regRbusy    = '0;
    rd_addr     = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_addr = regRaddr[k*AW +: AW];
      if (valid_addr(rd_addr)) begin
        for (int i = REG0 + 1; i < DEPTH; i++) begin
          if (rd_addr == AW'(i)) begin
            regRcontent[k*WIDTH +: WIDTH] = mem_q[i];
            regRbusy[k]                   = busy[i];
          end
        end
        if ((BYPASS != 0) && wr_en && (rd_addr == regWaddr)) begin
          regRcontent[k*WIDTH +: WIDTH] = data;
          regRbusy[k]                   = 1'b0;
        end
      end
    end
  end

  // Busy bits are registered, so this reflects state after the last edge only.
  assign anyBusy = |busy;

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default, no-forwarding, and DEPTH=24/NREAD=3 instances.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after that.
// All three instances share the write/issue inputs; each has its own read addresses.
module tb_regfile_multiport;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] iaddr = '0;
  logic [31:0]   wdata = '0;
  logic          wflag = 1'b0;
  logic          iflag = 1'b0;

  logic [2*AW-1:0] m_raddr = '0;
  logic [63:0]     m_rc;
  logic [1:0]      m_rb;
  logic            m_any;

  logic [2*AW-1:0] n_raddr = '0;
  logic [63:0]     n_rc;
  logic [1:0]      n_rb;
  logic            n_any;

  logic [3*AW-1:0] s_raddr = '0;
  logic [95:0]     s_rc;
  logic [2:0]      s_rb;
  logic            s_any;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_multiport u_main (
    .clk(clk), .rst_n(rst_n), .regRaddr(m_raddr), .regRcontent(m_rc), .regRbusy(m_rb),
    .regWaddr(waddr), .data(wdata), .regWflag(wflag), .issueFlag(iflag),
    .issueAddr(iaddr), .anyBusy(m_any)
  );

  regfile_multiport #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .regRaddr(n_raddr), .regRcontent(n_rc), .regRbusy(n_rb),
    .regWaddr(waddr), .data(wdata), .regWflag(wflag), .issueFlag(iflag),
    .issueAddr(iaddr), .anyBusy(n_any)
  );

  regfile_multiport #(.DEPTH(24), .NREAD(3)) u_small (
    .clk(clk), .rst_n(rst_n), .regRaddr(s_raddr), .regRcontent(s_rc), .regRbusy(s_rb),
    .regWaddr(waddr), .data(wdata), .regWflag(wflag), .issueFlag(iflag),
    .issueAddr(iaddr), .anyBusy(s_any)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset state
    settle();
    check("rst_m_p0", m_rc[31:0], 32'h0);
    check("rst_m_any", {31'b0, m_any}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // r17 write, read on both ports next cycle
    waddr = 5'd17; wdata = 32'hDEADBEEF; wflag = 1'b1;
    m_raddr = {5'd17, 5'd17}; n_raddr = {5'd17, 5'd17};
    tick();
    wflag = 1'b0;
    settle();
    check("r17_m_p0", m_rc[31:0], 32'hDEADBEEF);
    check("r17_m_p1", m_rc[63:32], 32'hDEADBEEF);
    check("r17_n_p0", n_rc[31:0], 32'hDEADBEEF);

    // r0 ignores writes and is never forwarded
    waddr = 5'd0; wdata = 32'hFFFFFFFF; wflag = 1'b1;
    m_raddr = {5'd0, 5'd0};
    settle();
    check("r0_fwd", m_rc[31:0], 32'h0);
    tick();
    wflag = 1'b0;
    settle();
    check("r0_after", m_rc[63:32], 32'h0);

    // Forwarding vs no forwarding on r19
    waddr = 5'd19; wdata = 32'h11111111; wflag = 1'b1;
    tick();
    wdata = 32'h12345678;
    m_raddr = {5'd19, 5'd0}; n_raddr = {5'd19, 5'd0};
    settle();
    check("byp_m_p1", m_rc[63:32], 32'h12345678);
    check("nobyp_old", n_rc[63:32], 32'h11111111);
    tick();
    wflag = 1'b0;
    settle();
    check("nobyp_new", n_rc[63:32], 32'h12345678);

    // DEPTH=24 instance: out-of-range address 30, then three ports r1,r2,r1
    waddr = 5'd1; wdata = 32'h00000101; wflag = 1'b1;
    tick();
    waddr = 5'd2; wdata = 32'h00000202;
    tick();
    waddr = 5'd30; wdata = 32'hAAAA5555; iaddr = 5'd30; iflag = 1'b1;
    s_raddr = {5'd30, 5'd30, 5'd30};
    settle();
    check("oor_fwd", s_rc[31:0], 32'h0);
    tick();
    iflag = 1'b0;
    settle();
    check("oor_read", s_rc[63:32], 32'h0);
    check("oor_busy", {29'b0, s_rb}, 32'h0);
    check("oor_any", {31'b0, s_any}, 32'h0);
    // write r30 again without issue so the 32-deep instances drop their busy bit
    tick();
    wflag = 1'b0;
    s_raddr = {5'd1, 5'd2, 5'd1};
    settle();
    check("s_p0_r1", s_rc[31:0], 32'h00000101);
    check("s_p1_r2", s_rc[63:32], 32'h00000202);
    check("s_p2_r1", s_rc[95:64], 32'h00000101);
    check("m_any_clr30", {31'b0, m_any}, 32'h0);

    // Busy scoreboard on r5
    iflag = 1'b1; iaddr = 5'd5;
    m_raddr = {5'd0, 5'd5}; n_raddr = {5'd0, 5'd5};
    settle();
    check("iss_busy_pre", {31'b0, m_rb[0]}, 32'h0);
    check("iss_any_pre", {31'b0, m_any}, 32'h0);
    tick();
    iflag = 1'b0;
    settle();
    check("iss_busy", {31'b0, m_rb[0]}, 32'h1);
    check("iss_any", {31'b0, m_any}, 32'h1);
    waddr = 5'd5; wdata = 32'h7; wflag = 1'b1;
    settle();
    check("wr_busy_fwd", {31'b0, m_rb[0]}, 32'h0);
    check("wr_busy_nobyp", {31'b0, n_rb[0]}, 32'h1);
    check("wr_any_pre", {31'b0, m_any}, 32'h1);
    tick();
    wflag = 1'b0;
    settle();
    check("wr_busy_clr", {31'b0, m_rb[0]}, 32'h0);
    check("wr_any_clr", {31'b0, m_any}, 32'h0);
    check("wr_r5", m_rc[31:0], 32'h7);
    iflag = 1'b1; iaddr = 5'd5; wflag = 1'b1; waddr = 5'd5; wdata = 32'h9;
    tick();
    iflag = 1'b0; wflag = 1'b0;
    settle();
    check("iw_busy", {31'b0, m_rb[0]}, 32'h1);
    check("iw_any", {31'b0, m_any}, 32'h1);
    check("iw_r5", m_rc[31:0], 32'h9);

    // Reset asserted mid-cycle with a write in flight
    m_raddr = {5'd17, 5'd5};
    waddr = 5'd17; wdata = 32'hCAFEF00D; wflag = 1'b1;
    #3;
    rst_n = 1'b0;
    settle();
    check("mrst_r17", m_rc[63:32], 32'h0);
    check("mrst_r5", m_rc[31:0], 32'h0);
    check("mrst_busy", {31'b0, m_rb[0]}, 32'h0);
    check("mrst_any", {31'b0, m_any}, 32'h0);
    check("mrst_n_any", {31'b0, n_any}, 32'h0);
    tick();
    check("mrst_edge_r17", m_rc[63:32], 32'h0);
    wflag = 1'b0;
    rst_n = 1'b1;
    tick();
    settle();
    check("post_rst_r17", m_rc[63:32], 32'h0);
    check("post_rst_any", {31'b0, m_any}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (>=2).
REQ-003 SHALL have parameter NREAD, default 2, number of independent read ports (>=1).
REQ-004 SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL derive localparam AW = max(1, clog2(DEPTH)), address width.
REQ-006 SHALL have port clk  input  1  single rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port regRaddr  input  NREAD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-009 SHALL have port regRcontent  output  NREAD*WIDTH  packed read data, port k at [k*WIDTH +: WIDTH].
REQ-010 SHALL have port regRbusy  output  NREAD  per-port pending-write flag for the addressed register.
REQ-011 SHALL have port regWaddr  input  AW  write address.
REQ-012 SHALL have port data  input  WIDTH  write data.
REQ-013 SHALL have port regWflag  input  1  write enable.
REQ-014 SHALL have port issueFlag  input  1  marks register issueAddr as awaiting a write.
REQ-015 SHALL have port issueAddr  input  AW  register to mark busy.
REQ-016 SHALL have port anyBusy  output  1  OR of all busy bits.

Function
REQ-017 Storage SHALL be DEPTH x WIDTH flops, written on rising clk when regWflag=1, regWaddr!=0 and regWaddr<DEPTH.
REQ-018 Register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-019 Reads SHALL be combinational, zero latency, all NREAD ports independent, any ports may share an address.
REQ-020 BYPASS=1: a read port whose address equals regWaddr (nonzero, in range) while regWflag=1 SHALL output data in that same cycle.
REQ-021 BYPASS=0: that read SHALL output the old value; the new value appears after the clock edge.
REQ-022 Addresses >=DEPTH SHALL read 0 and busy 0; writes and issues to them SHALL be ignored.
REQ-023 busy[i] SHALL set on rising clk when issueFlag=1 and issueAddr=i (i!=0, in range).
REQ-024 busy[i] SHALL clear on rising clk when a write to i occurs and no issue to i occurs in the same cycle.
REQ-025 Simultaneous issue and write to the same register SHALL store data and leave busy[i]=1 (newer producer wins).
REQ-026 regRbusy[k] SHALL equal busy[regRaddr_k], forced to 0 in a cycle where BYPASS=1 and the forwarded write targets that address.
REQ-027 anyBusy SHALL be the registered OR of busy bits (reflects state after the last edge, no bypass).

Reset
REQ-028 rst_n=0 SHALL immediately clear all registers and busy bits, independent of clk; regRcontent, regRbusy and anyBusy are then 0.
REQ-029 Writes and issues SHALL be ignored while rst_n=0; first update occurs at the first rising clk after rst_n rises.
REQ-030 Reset asserted mid-operation SHALL discard any pending busy state without completing the in-flight write.

Structure
REQ-031 Shared package SHALL hold default WIDTH/DEPTH constants and the reg-0 index constant; no typedefs beyond word type.
REQ-032 Busy tracking SHALL be a sub-module regfile_scoreboard (DEPTH, AW params; issue/clear inputs, busy vector output).
REQ-033 Target size 120-400 lines RTL total; no memories inferred as RAM macros.

Verification
REQ-034 Reset: drive rst_n=0 mid-clock after writes -> all reads 0, anyBusy=0 before next edge.
REQ-035 Write 0xDEADBEEF to r17, read r17 on ports 0 and 1 next cycle -> both 0xDEADBEEF; write r0=0xFFFFFFFF -> r0 reads 0.
REQ-036 BYPASS=1, write 0x12345678 to r19 while port1 reads r19 -> 0x12345678 same cycle; BYPASS=0 -> old value, new after edge.
REQ-037 Issue r5, next cycle regRbusy=1 and anyBusy=1; write r5=7 -> busy clears after edge; issue+write r5 same cycle -> busy stays 1, r5=data.
REQ-038 DEPTH=24, NREAD=3: write/issue address 30 -> ignored, read 30 -> 0, busy 0; three ports reading r1,r2,r1 return correct values.
